// File: rtl/fifo_to_custom_ip_reader_pkg.sv
// Shared packet layout for the FIFO <-> Custom IP adapters.
// Field positions are the inverse of the Custom-IP-to-FIFO packing.
package fifo_to_custom_ip_reader_pkg;

  localparam int PACKET_SIZE_BITS = 256;

  localparam int BS_ID_W   = 8;
  localparam int FPGA_ID_W = 8;
  localparam int PCKG_ID_W = 16;
  localparam int TX_UID_W  = 8;
  localparam int RX_UID_W  = 8;
  localparam int VPB_W     = 16;
  localparam int MSG_W     = 32;
  localparam int NUM_MSG   = 6;

  localparam int BS_ID_MSB   = 255;
  localparam int BS_ID_LSB   = 248;
  localparam int FPGA_ID_MSB = 247;
  localparam int FPGA_ID_LSB = 240;
  localparam int PCKG_ID_MSB = 239;
  localparam int PCKG_ID_LSB = 224;
  localparam int TX_UID_MSB  = 223;
  localparam int TX_UID_LSB  = 216;
  localparam int RX_UID_MSB  = 215;
  localparam int RX_UID_LSB  = 208;
  localparam int VPB_MSB     = 207;
  localparam int VPB_LSB     = 192;

  localparam int MSG0_LSB = 160;
  localparam int MSG1_LSB = 128;
  localparam int MSG2_LSB = 96;
  localparam int MSG3_LSB = 64;
  localparam int MSG4_LSB = 32;
  localparam int MSG5_LSB = 0;

  // Encodings equal the number of buffered packets.
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

  function automatic logic [1:0] inflight(
    input logic [1:0] occ,
    input logic       pending
  );
    return occ + {1'b0, pending};
  endfunction

endpackage

// File: rtl/fifo_to_custom_ip_reader_pkt.sv
// Two-entry head/tail packet buffer (pkt_skid_buffer).
// Head is always the oldest packet; tail only holds data in OCC_TWO.
module pkt_skid_buffer
  import fifo_to_custom_ip_reader_pkg::*;
#(
  parameter int W = 256
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic [W-1:0] head_o,
  output logic [1:0]   occ_o
);

  occ_e         occ_q, occ_d;
  logic [W-1:0] head_q, head_d;
  logic [W-1:0] tail_q, tail_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_q  <= OCC_EMPTY;
      head_q <= '0;
      tail_q <= '0;
    end else begin
      occ_q  <= occ_d;
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  always_comb begin
    occ_d  = occ_q;
    head_d = head_q;
    tail_d = tail_q;
    unique case (occ_q)
      OCC_EMPTY: begin
        if (push_i) begin
          occ_d  = OCC_ONE;
          head_d = data_i;
        end
      end
      OCC_ONE: begin
        if (push_i && pop_i) begin
          head_d = data_i;
        end else if (push_i) begin
          occ_d  = OCC_TWO;
          tail_d = data_i;
        end else if (pop_i) begin
          occ_d = OCC_EMPTY;
        end
      end
      OCC_TWO: begin
        // Upstream never issues a capture here without a pop.
        if (pop_i) begin
          occ_d  = OCC_ONE;
          head_d = tail_q;
        end
      end
      default: begin
        occ_d = OCC_EMPTY;
      end
    endcase
  end

  assign head_o = head_q;
  assign occ_o  = occ_q;

endmodule

// File: rtl/fifo_to_custom_ip_reader.sv
// Standard-mode FIFO to Custom IP field adapter.
// Optional PKT_COUNT_EN adds a saturating delivered-packet counter.
module fifo_to_custom_ip_reader #(
  parameter int PACKET_SIZE_BITS =
    fifo_to_custom_ip_reader_pkg::PACKET_SIZE_BITS
) (
  input  logic                        clk,
  input  logic                        rst,
  output logic                        rd_en,
  input  logic [PACKET_SIZE_BITS-1:0] dout,
  input  logic                        empty,
  output logic                        in_fifo_V_BS_ID_empty_n,
  input  logic                        in_fifo_V_BS_ID_read,
  output logic [7:0]                  in_fifo_V_BS_ID_dout,
  output logic [7:0]                  in_fifo_V_FPGA_ID_dout,
  output logic [15:0]                 in_fifo_V_PCKG_ID_dout,
  output logic [7:0]                  in_fifo_V_TX_UID_dout,
  output logic [7:0]                  in_fifo_V_RX_UID_dout,
  output logic [15:0]                 in_fifo_V_VALID_PACKET_BYTES_dout,
  output logic [31:0]                 in_fifo_V_MESSAGE_0_dout,
  output logic [31:0]                 in_fifo_V_MESSAGE_1_dout,
  output logic [31:0]                 in_fifo_V_MESSAGE_2_dout,
  output logic [31:0]                 in_fifo_V_MESSAGE_3_dout,
  output logic [31:0]                 in_fifo_V_MESSAGE_4_dout,
  output logic [31:0]                 in_fifo_V_MESSAGE_5_dout
`ifdef PKT_COUNT_EN
  ,
  output logic [31:0]                 pkt_count
`endif
);

  import fifo_to_custom_ip_reader_pkg::*;

  logic                        pop;
  logic                        pending_q, pending_d;
  logic [1:0]                  occ;
  logic [1:0]                  infl;
  logic [PACKET_SIZE_BITS-1:0] head;

  assign pop = in_fifo_V_BS_ID_read & in_fifo_V_BS_ID_empty_n;
  assign infl = inflight(occ, pending_q);

  // A slot freed by this cycle's pop may be refilled immediately.
  always_comb begin
    rd_en = 1'b0;
    if (!rst && !empty) begin
      rd_en = (infl < 2'd2) || ((infl == 2'd2) && pop);
    end
  end

  assign pending_d = rd_en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q <= 1'b0;
    end else begin
      pending_q <= pending_d;
    end
  end

  pkt_skid_buffer #(
    .W (PACKET_SIZE_BITS)
  ) u_buf (
    .clk    (clk),
    .rst    (rst),
    .push_i (pending_q),
    .data_i (dout),
    .pop_i  (pop),
    .head_o (head),
    .occ_o  (occ)
  );

  assign in_fifo_V_BS_ID_empty_n = (occ != OCC_EMPTY);

  assign in_fifo_V_BS_ID_dout =
    head[BS_ID_MSB:BS_ID_LSB];
  assign in_fifo_V_FPGA_ID_dout =
    head[FPGA_ID_MSB:FPGA_ID_LSB];
  assign in_fifo_V_PCKG_ID_dout =
    head[PCKG_ID_MSB:PCKG_ID_LSB];
  assign in_fifo_V_TX_UID_dout =
    head[TX_UID_MSB:TX_UID_LSB];
  assign in_fifo_V_RX_UID_dout =
    head[RX_UID_MSB:RX_UID_LSB];
  assign in_fifo_V_VALID_PACKET_BYTES_dout =
    head[VPB_MSB:VPB_LSB];
  assign in_fifo_V_MESSAGE_0_dout =
    head[MSG0_LSB+MSG_W-1:MSG0_LSB];
  assign in_fifo_V_MESSAGE_1_dout =
    head[MSG1_LSB+MSG_W-1:MSG1_LSB];
  assign in_fifo_V_MESSAGE_2_dout =
    head[MSG2_LSB+MSG_W-1:MSG2_LSB];
  assign in_fifo_V_MESSAGE_3_dout =
    head[MSG3_LSB+MSG_W-1:MSG3_LSB];
  assign in_fifo_V_MESSAGE_4_dout =
    head[MSG4_LSB+MSG_W-1:MSG4_LSB];
  assign in_fifo_V_MESSAGE_5_dout =
    head[MSG5_LSB+MSG_W-1:MSG5_LSB];

`ifdef PKT_COUNT_EN
  logic [31:0] pkt_count_q, pkt_count_d;

  always_comb begin
    pkt_count_d = pkt_count_q;
    if (pop && (pkt_count_q != 32'hFFFF_FFFF)) begin
      pkt_count_d = pkt_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pkt_count_q <= '0;
    end else begin
      pkt_count_q <= pkt_count_d;
    end
  end

  assign pkt_count = pkt_count_q;
`endif

endmodule

// File: tb/tb_fifo_to_custom_ip_reader.sv
// Scoreboard bench for fifo_to_custom_ip_reader.
// Stimulus queues expected packets; a negedge monitor checks each pop.
module tb_fifo_to_custom_ip_reader;

  logic         clk = 1'b0;
  logic         rst;
  logic         rd_en;
  logic [255:0] dout;
  logic         empty;
  logic         empty_n;
  logic         read;
  logic [7:0]   bs, fpga, tx, rx;
  logic [15:0]  pckg, vpb;
  logic [31:0]  m0, m1, m2, m3, m4, m5;
`ifdef PKT_COUNT_EN
  logic [31:0]  pkt_count;
  logic [31:0]  cnt_before;
`endif

  always #5 clk = ~clk;

  fifo_to_custom_ip_reader dut (
    .clk                               (clk),
    .rst                               (rst),
    .rd_en                             (rd_en),
    .dout                              (dout),
    .empty                             (empty),
    .in_fifo_V_BS_ID_empty_n           (empty_n),
    .in_fifo_V_BS_ID_read              (read),
    .in_fifo_V_BS_ID_dout              (bs),
    .in_fifo_V_FPGA_ID_dout            (fpga),
    .in_fifo_V_PCKG_ID_dout            (pckg),
    .in_fifo_V_TX_UID_dout             (tx),
    .in_fifo_V_RX_UID_dout             (rx),
    .in_fifo_V_VALID_PACKET_BYTES_dout (vpb),
    .in_fifo_V_MESSAGE_0_dout          (m0),
    .in_fifo_V_MESSAGE_1_dout          (m1),
    .in_fifo_V_MESSAGE_2_dout          (m2),
    .in_fifo_V_MESSAGE_3_dout          (m3),
    .in_fifo_V_MESSAGE_4_dout          (m4),
    .in_fifo_V_MESSAGE_5_dout          (m5)
`ifdef PKT_COUNT_EN
    ,
    .pkt_count                         (pkt_count)
`endif
  );

  logic [255:0] fifo_q[$];
  logic [255:0] exp_q[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int npop = 0;
  int first_pop = 0;
  int last_pop = 0;
  int rd_pulses = 0;
  logic re_s = 1'b0;
  logic s_rd, s_en;
  logic [7:0]  s_bs, s_fpga;
  logic [31:0] s_m0, s_m5;
  logic [255:0] got_w, exp_w;

  function automatic logic [255:0] mkpkt(
    input logic [7:0]  b,
    input logic [31:0] msg5,
    input logic [7:0]  k
  );
    return {b, 8'h5A, 8'hC0, k, 8'h01, 8'h02, 8'h00, k,
            32'h1010_1010, 32'h2020_2020, 32'h3030_3030,
            32'h4040_4040, 24'h50_5050, k, msg5};
  endfunction

  task automatic chk(input string nm, input logic [255:0] act,
                     input logic [255:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s act=%0h req=%0h", nm, act, req);
    end
  endtask

  task automatic push(input logic [255:0] p);
    fifo_q.push_back(p);
    exp_q.push_back(p);
    empty = 1'b0;
  endtask

  // Negedge snapshot, then FIFO model update just after the edge.
  task automatic tick();
    @(negedge clk);
    cyc++;
    re_s   = rd_en;
    s_rd   = rd_en;
    s_en   = empty_n;
    s_bs   = bs;
    s_fpga = fpga;
    s_m0   = m0;
    s_m5   = m5;
    if (rd_en) rd_pulses++;
    if (empty_n && read && !rst) begin
      npop++;
      if (npop == 1) first_pop = cyc;
      last_pop = cyc;
    end
    @(posedge clk);
    #1;
    if (re_s && fifo_q.size() > 0) dout = fifo_q.pop_front();
    empty = (fifo_q.size() == 0);
  endtask

  task automatic drain(input string nm, input int budget);
    read = 1'b1;
    for (int i = 0; i < budget && exp_q.size() > 0; i++) tick();
    chk(nm, exp_q.size(), 0);
    read = 1'b0;
    tick();
  endtask

  always @(negedge clk) begin
    if (!rst && empty_n && read) begin
      got_w = {bs, fpga, pckg, tx, rx, vpb, m0, m1, m2, m3, m4, m5};
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL pop_unexpected act=%0h req=none", got_w);
      end else begin
        exp_w = exp_q.pop_front();
        if (got_w !== exp_w) begin
          bad++;
          $display("FAIL pop_data act=%0h req=%0h", got_w, exp_w);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout act=running req=finished");
    $fatal(1);
  end

  initial begin
    rst   = 1'b1;
    read  = 1'b0;
    dout  = '0;
    empty = 1'b0;
    tick();
    tick();
    chk("rst_rd_en", s_rd, 0);
    chk("rst_empty_n", s_en, 0);
    chk("rst_bs", s_bs, 0);
    chk("rst_m5", s_m5, 0);
    empty = 1'b1;
    rst   = 1'b0;
    tick();

    // Single packet, read held low.
    push(mkpkt(8'hAA, 32'h1234_5678, 8'h00));
    tick();
    chk("sp_rd_en", s_rd, 1);
    tick();
    chk("sp_rd_en_off", s_rd, 0);
    chk("sp_en_early", s_en, 0);
    tick();
    chk("sp_en", s_en, 1);
    chk("sp_bs", s_bs, 8'hAA);
    chk("sp_fpga", s_fpga, 8'h5A);
    chk("sp_m0", s_m0, 32'h1010_1010);
    chk("sp_m5", s_m5, 32'h1234_5678);
    tick();
    tick();
    chk("sp_en_hold", s_en, 1);
    chk("sp_bs_hold", s_bs, 8'hAA);
    drain("sp_drain", 5);

    // Spurious read while nothing is buffered.
    npop = 0;
    read = 1'b1;
    tick();
    tick();
    tick();
    chk("spur_en", s_en, 0);
    chk("spur_rd", s_rd, 0);
    chk("spur_npop", npop, 0);
    read = 1'b0;

    // Streaming: one pop per cycle after 2-cycle fill.
`ifdef PKT_COUNT_EN
    cnt_before = pkt_count;
`endif
    npop = 0;
    cyc  = 0;
    for (int k = 0; k < 10; k++)
      push(mkpkt(8'h10 + 8'(k), 32'hA000_0000 + k, 8'(k)));
    read = 1'b1;
    for (int i = 0; i < 30 && exp_q.size() > 0; i++) tick();
    chk("st_left", exp_q.size(), 0);
    chk("st_npop", npop, 10);
    chk("st_first", first_pop, 3);
    chk("st_span", last_pop - first_pop, 9);
    read = 1'b0;
    tick();
`ifdef PKT_COUNT_EN
    chk("st_count", pkt_count - cnt_before, 10);
`endif

    // Backpressure: only two words leave the FIFO.
    rd_pulses = 0;
    npop = 0;
    for (int k = 0; k < 5; k++)
      push(mkpkt(8'h60 + 8'(k), 32'hB000_0000 + k, 8'(k)));
    for (int i = 0; i < 8; i++) tick();
    chk("bp_pulses", rd_pulses, 2);
    chk("bp_en", s_en, 1);
    chk("bp_fifo", fifo_q.size(), 3);
    chk("bp_head", s_bs, 8'h60);
    drain("bp_drain", 30);
    chk("bp_npop", npop, 5);

    // Reset the cycle after rd_en with one packet buffered.
    push(mkpkt(8'hC1, 32'hC100_0001, 8'h01));
    tick();
    tick();
    tick();
    chk("rm_one", s_en, 1);
    push(mkpkt(8'hC2, 32'hC200_0002, 8'h02));
    tick();
    chk("rm_rd_en", s_rd, 1);
    rst = 1'b1;
    exp_q.delete();
    tick();
    chk("rm_en", s_en, 0);
    chk("rm_rd", s_rd, 0);
    chk("rm_bs", s_bs, 0);
    chk("rm_m5", s_m5, 0);
    rst = 1'b0;
    tick();
    tick();
    tick();
    chk("rm_stay_empty", s_en, 0);
    push(mkpkt(8'hC3, 32'hC300_0003, 8'h03));
    drain("rm_drain", 10);

`ifdef PKT_COUNT_EN
    dut.pkt_count_q = 32'hFFFF_FFFE;
    for (int k = 0; k < 3; k++)
      push(mkpkt(8'hE0 + 8'(k), 32'hE000_0000 + k, 8'(k)));
    drain("sat_drain", 20);
    chk("sat_count", pkt_count, 32'hFFFF_FFFF);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_to_custom_ip_reader.md
FIFO_TO_CUSTOM_IP_READER -- requirements
Module: fifo_to_custom_ip_reader

Interface
REQ-001 The block SHALL have one parameter: PACKET_SIZE_BITS, default 256, width of the FIFO read word (256 is the only supported value).
REQ-002 The block SHALL have one clock and an asynchronous, active-high reset, with these ports:
- clk  input  1  sole clock; all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- rd_en  output  1  read strobe to the standard-mode FIFO (read latency 1).
- dout  input  PACKET_SIZE_BITS  FIFO read data, valid the cycle after rd_en.
- empty  input  1  FIFO empty flag.
- in_fifo_V_BS_ID_empty_n  output  1  packet available to the Custom IP.
- in_fifo_V_BS_ID_read  input  1  Custom IP consumes the head packet.
- in_fifo_V_BS_ID_dout  output  8  head packet bits [255:248].
- in_fifo_V_FPGA_ID_dout  output  8  bits [247:240].
- in_fifo_V_PCKG_ID_dout  output  16  bits [239:224].
- in_fifo_V_TX_UID_dout  output  8  bits [223:216].
- in_fifo_V_RX_UID_dout  output  8  bits [215:208].
- in_fifo_V_VALID_PACKET_BYTES_dout  output  16  bits [207:192].
- in_fifo_V_MESSAGE_0_dout .. in_fifo_V_MESSAGE_5_dout  output  32 each  MESSAGE_k = bits [191-32k:160-32k].
- pkt_count  output  32  packets delivered (present only with PKT_COUNT_EN).

Function
REQ-003 All fields SHALL share the BS_ID handshake; no other per-field empty_n/read ports exist.
REQ-004 The block SHALL hold a 2-entry packet buffer (head, tail) with occupancy states EMPTY, ONE, TWO, plus a 1-bit pending flag for a FIFO read in flight.
REQ-005 pop = in_fifo_V_BS_ID_read AND in_fifo_V_BS_ID_empty_n; read while empty_n=0 SHALL be ignored.
REQ-006 rd_en SHALL be !empty AND (occ+pending < 2 OR (occ+pending == 2 AND pop)), so one packet per cycle is sustained and the buffer never overflows.
REQ-007 pending SHALL be set the cycle after rd_en=1 and cleared otherwise; dout SHALL be captured into the buffer when pending=1.
REQ-008 in_fifo_V_BS_ID_empty_n SHALL be 1 exactly when occ != EMPTY; field outputs SHALL show the head entry, registered, unchanged while not popped.
REQ-009 Transitions: EMPTY->ONE on capture; ONE->TWO on capture without pop; ONE->EMPTY on pop without capture; ONE stays on capture+pop (captured word becomes head); TWO->ONE on pop (tail moves to head); capture cannot occur in TWO without pop.
REQ-010 Latency: FIFO non-empty with the block idle -> rd_en same cycle -> empty_n=1 two cycles after rd_en.
REQ-011 Packet order SHALL be preserved; no packet is duplicated or dropped outside reset.
REQ-012 Field extraction SHALL be the exact inverse of the Custom-IP-to-FIFO packing (BS_ID at MSB, MESSAGE_5 at LSB).

Reset
REQ-013 While rst=1: rd_en=0, empty_n=0, all field outputs 0, occ=EMPTY, pending=0, pkt_count=0.
REQ-014 A reset asserted with a read pending or packets buffered SHALL discard them; those FIFO words are lost.

Configuration
REQ-015 Macro PKT_COUNT_EN: when defined, pkt_count exists and increments by 1 per pop, saturating at 0xFFFFFFFF; when undefined, neither the port nor the counter exists and all other behaviour is identical.

Structure
REQ-016 A shared package SHALL hold PACKET_SIZE_BITS, the field widths, and the field MSB/LSB constants, used by both directions' adapters.
REQ-017 The 2-entry buffer SHALL be a sub-module named pkt_skid_buffer; field slicing stays in the top.

Verification
REQ-018 Single packet: FIFO holds 0xAA..(BS_ID=0xAA, MESSAGE_5=0x12345678), read held 0 -> rd_en one cycle, empty_n=1 two cycles later, fields match, empty_n stays 1.
REQ-019 Streaming: 10 packets, read held 1 -> after the initial 2-cycle fill, one pop per cycle, order preserved, pkt_count=10 (PKT_COUNT_EN).
REQ-020 Backpressure: 5 packets, read=0 -> exactly 2 rd_en pulses, occ=TWO; then read=1 -> all 5 delivered in order.
REQ-021 Spurious read: read=1 while empty_n=0 -> no state change, pkt_count unchanged.
REQ-022 Reset mid-flight: rst asserted the cycle after rd_en with occ=ONE -> all outputs 0 next edge, empty_n=0, discarded packet never appears.
REQ-023 Saturation: preload pkt_count to 0xFFFFFFFE, pop 3 -> 0xFFFFFFFF.
